// File: rtl/fifo_push_arbiter_if.sv
// Push-side bundle between the requesters, the consumer strobe and the shared FIFO push port.
// The master view belongs to the arbiter; the slave view belongs to requesters, consumer and FIFO.
interface fifo_push_arbiter_if #(
   parameter int NUM_REQ = 4,
   parameter int DATA_W  = 32,
   parameter int LEN_W   = 6
) ();
   logic [NUM_REQ-1:0]        Req;
   logic [NUM_REQ*LEN_W-1:0]  Req_Len;
   logic [NUM_REQ*DATA_W-1:0] Req_Data;
   logic [NUM_REQ-1:0]        Req_Valid;
   logic [NUM_REQ-1:0]        Grant;
   logic [DATA_W-1:0]         Fifo_DIN;
   logic                      Fifo_PUSH;
   logic                      Fifo_POP;
   logic                      Fifo_Push_Flush;
   logic                      Flush_Req;
   logic                      Flush_Busy;
   logic [9:0]                Level;
   logic                      Underflow;

   modport master (
      input  Req, Req_Len, Req_Data, Req_Valid, Fifo_POP, Flush_Req,
      output Grant, Fifo_DIN, Fifo_PUSH, Fifo_Push_Flush, Flush_Busy, Level, Underflow
   );

   modport slave (
      output Req, Req_Len, Req_Data, Req_Valid, Fifo_POP, Flush_Req,
      input  Grant, Fifo_DIN, Fifo_PUSH, Fifo_Push_Flush, Flush_Busy, Level, Underflow
   );
endinterface

// File: rtl/fifo_push_arbiter.sv
// Round-robin burst arbiter for the push port of a single-clock 512x32 FIFO. A burst is granted
// only when the FIFO can absorb all of it; occupancy is tracked from issued pushes and seen pops.
module fifo_push_arbiter #(
   parameter int NUM_REQ   = 4,
   parameter int DATA_W    = 32,
   parameter int DEPTH     = 512,
   parameter int LEN_W     = 6,
   parameter int MAX_BURST = 32,
   parameter int FLUSH_CYC = 2
) (
   input logic                 Clk,
   input logic                 Reset_N,
   fifo_push_arbiter_if.master bus
);
   localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int BEAT_W = $clog2(MAX_BURST + 1);
   localparam int LVL_W  = 10;
   localparam int FCNT_W = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BURST = 2'd1,
      FLUSH = 2'd2
   } state_t;

   state_t              state_r, state_nx_s;
   logic [NUM_REQ-1:0]  grant_r, grant_nx_s;
   logic [IDX_W-1:0]    owner_r, owner_nx_s;
   logic [IDX_W-1:0]    rr_r, rr_nx_s;
   logic [IDX_W-1:0]    cand_s, hit_idx_s;
   logic                hit_s;
   logic [BEAT_W-1:0]   beats_r, beats_nx_s;
   logic [BEAT_W-1:0]   cand_len_s, hit_len_s;
   logic [LVL_W-1:0]    level_r, level_nx_s;
   logic [LVL_W-1:0]    committed_r, committed_nx_s;
   logic [LVL_W-1:0]    free_s;
   logic                latch_r, latch_nx_s;
   logic [FCNT_W-1:0]   fcnt_r, fcnt_nx_s;
   logic [DATA_W-1:0]   din_r, din_nx_s;
   logic                push_r, push_nx_s;
   logic                pflush_r, pflush_nx_s;
   logic                busy_r, busy_nx_s;
   logic                under_r, under_nx_s;
   logic                pop_ok_s;
   logic                accept_s;

   function automatic logic [BEAT_W-1:0] eff_len(input logic [LEN_W-1:0] len);
      logic [BEAT_W-1:0] r;
      if (int'(len) > MAX_BURST) r = BEAT_W'(MAX_BURST);
      else                       r = BEAT_W'(len);
      return r;
   endfunction

   function automatic logic [IDX_W-1:0] wrap_idx(input logic [IDX_W-1:0] base, input int step);
      int s;
      s = int'(base) + step;
      if (s >= NUM_REQ) s = s - NUM_REQ;
      return IDX_W'(s);
   endfunction

   // Room left once the in-flight burst lands; a grant needs its whole clamped length to fit.
   assign free_s = LVL_W'(DEPTH) - committed_r;

   // Next-state, occupancy and registered-output logic.
   always_comb begin
      state_nx_s     = state_r;
      grant_nx_s     = grant_r;
      owner_nx_s     = owner_r;
      rr_nx_s        = rr_r;
      beats_nx_s     = beats_r;
      latch_nx_s     = latch_r;
      fcnt_nx_s      = fcnt_r;
      din_nx_s       = din_r;
      push_nx_s      = 1'b0;
      pflush_nx_s    = 1'b0;
      hit_s          = 1'b0;
      hit_idx_s      = '0;
      hit_len_s      = '0;
      cand_s         = '0;
      cand_len_s     = '0;

      pop_ok_s   = bus.Fifo_POP && (level_r != '0) && (state_r != FLUSH);
      under_nx_s = bus.Fifo_POP && (level_r == '0) && (state_r != FLUSH);
      accept_s   = (state_r == BURST) && bus.Req_Valid[owner_r];

      case ({push_r, pop_ok_s})
         2'b10:   level_nx_s = level_r + LVL_W'(1);
         2'b01:   level_nx_s = level_r - LVL_W'(1);
         default: level_nx_s = level_r;
      endcase

      if (pop_ok_s) committed_nx_s = committed_r - LVL_W'(1);
      else          committed_nx_s = committed_r;

      // Skip requesters that do not fit so one large burst cannot stall the others.
      for (int k = 0; k < NUM_REQ; k++) begin
         cand_s     = wrap_idx(rr_r, k);
         cand_len_s = eff_len(bus.Req_Len[int'(cand_s)*LEN_W +: LEN_W]);
         if (!hit_s && bus.Req[cand_s] && (cand_len_s != '0) &&
             (LVL_W'(cand_len_s) <= free_s)) begin
            hit_s     = 1'b1;
            hit_idx_s = cand_s;
            hit_len_s = cand_len_s;
         end else begin
            hit_s = hit_s;
         end
      end

      case (state_r)
         IDLE: begin
            if (bus.Flush_Req || latch_r) begin
               state_nx_s  = FLUSH;
               latch_nx_s  = 1'b0;
               fcnt_nx_s   = '0;
               pflush_nx_s = 1'b1;
            end else if (hit_s) begin
               state_nx_s             = BURST;
               grant_nx_s             = '0;
               grant_nx_s[hit_idx_s]  = 1'b1;
               owner_nx_s             = hit_idx_s;
               beats_nx_s             = hit_len_s;
               committed_nx_s         = committed_nx_s + LVL_W'(hit_len_s);
               rr_nx_s                = wrap_idx(hit_idx_s, 1);
            end else begin
               state_nx_s = IDLE;
            end
         end
         BURST: begin
            if (bus.Flush_Req) latch_nx_s = 1'b1;
            else               latch_nx_s = latch_r;
            if (accept_s) begin
               push_nx_s  = 1'b1;
               din_nx_s   = bus.Req_Data[int'(owner_r)*DATA_W +: DATA_W];
               beats_nx_s = beats_r - BEAT_W'(1);
               if (beats_r == BEAT_W'(1)) begin
                  state_nx_s = IDLE;
                  grant_nx_s = '0;
               end else begin
                  state_nx_s = BURST;
               end
            end else begin
               beats_nx_s = beats_r;
            end
         end
         FLUSH: begin
            if (fcnt_r == FCNT_W'(FLUSH_CYC - 1)) begin
               state_nx_s     = IDLE;
               level_nx_s     = '0;
               committed_nx_s = '0;
            end else begin
               fcnt_nx_s   = fcnt_r + FCNT_W'(1);
               pflush_nx_s = 1'b1;
            end
         end
         default: begin
            state_nx_s = IDLE;
            grant_nx_s = '0;
         end
      endcase

      busy_nx_s = (state_nx_s == FLUSH) || latch_nx_s;
   end

   // State and output registers.
   always_ff @(posedge Clk or negedge Reset_N) begin
      if (!Reset_N) begin
         state_r     <= IDLE;
         grant_r     <= '0;
         owner_r     <= '0;
         rr_r        <= '0;
         beats_r     <= '0;
         level_r     <= '0;
         committed_r <= '0;
         latch_r     <= 1'b0;
         fcnt_r      <= '0;
         din_r       <= '0;
         push_r      <= 1'b0;
         pflush_r    <= 1'b0;
         busy_r      <= 1'b0;
         under_r     <= 1'b0;
      end else begin
         state_r     <= state_nx_s;
         grant_r     <= grant_nx_s;
         owner_r     <= owner_nx_s;
         rr_r        <= rr_nx_s;
         beats_r     <= beats_nx_s;
         level_r     <= level_nx_s;
         committed_r <= committed_nx_s;
         latch_r     <= latch_nx_s;
         fcnt_r      <= fcnt_nx_s;
         din_r       <= din_nx_s;
         push_r      <= push_nx_s;
         pflush_r    <= pflush_nx_s;
         busy_r      <= busy_nx_s;
         under_r     <= under_nx_s;
      end
   end

   assign bus.Grant           = grant_r;
   assign bus.Fifo_DIN        = din_r;
   assign bus.Fifo_PUSH       = push_r;
   assign bus.Fifo_Push_Flush = pflush_r;
   assign bus.Flush_Busy      = busy_r;
   assign bus.Level           = level_r;
   assign bus.Underflow       = under_r;
endmodule

// File: tb/tb_fifo_push_arbiter.sv
// Randomised bench for fifo_push_arbiter: requesters, consumer pops and flush pulses are random;
// every output is compared each cycle against a transaction-level model of the arbitration rules.
module tb_fifo_push_arbiter;
   localparam int NUM_REQ   = 4;
   localparam int DATA_W    = 32;
   localparam int DEPTH     = 512;
   localparam int LEN_W     = 6;
   localparam int MAX_BURST = 32;
   localparam int FLUSH_CYC = 2;

   logic Clk;
   logic Reset_N;

   fifo_push_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .LEN_W(LEN_W)) bus ();

   fifo_push_arbiter #(
      .NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .DEPTH(DEPTH), .LEN_W(LEN_W),
      .MAX_BURST(MAX_BURST), .FLUSH_CYC(FLUSH_CYC)
   ) dut (
      .Clk(Clk),
      .Reset_N(Reset_N),
      .bus(bus)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   int n_cmp;
   int n_err;

   // stimulus currently applied to the DUT
   logic [NUM_REQ-1:0] in_req;
   logic [NUM_REQ-1:0] in_valid;
   int                 in_len  [NUM_REQ];
   logic [DATA_W-1:0]  in_data [NUM_REQ];
   logic               in_pop;
   logic               in_fl;

   // reference model: mode 0 = idle, 1 = burst in progress, 2 = flushing
   int                m_mode, m_owner, m_left, m_fl_left, m_rr, m_level, m_comm, new_grant;
   bit                m_latch, e_push, e_flush, e_busy, e_under;
   logic [DATA_W-1:0] e_din;
   int                m_pushes, d_pushes;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] want);
      n_cmp++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, want, $time);
      end
   endtask

   task automatic drive_inputs();
      bus.Req       = in_req;
      bus.Req_Valid = in_valid;
      for (int i = 0; i < NUM_REQ; i++) begin
         bus.Req_Len[i*LEN_W +: LEN_W]    = LEN_W'(in_len[i]);
         bus.Req_Data[i*DATA_W +: DATA_W] = in_data[i];
      end
      bus.Fifo_POP  = in_pop;
      bus.Flush_Req = in_fl;
   endtask

   task automatic clear_inputs();
      in_req   = '0;
      in_valid = '0;
      in_pop   = 1'b0;
      in_fl    = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         in_len[i]  = 0;
         in_data[i] = '0;
      end
      drive_inputs();
   endtask

   task automatic model_reset();
      m_mode = 0; m_owner = 0; m_left = 0; m_fl_left = 0; m_rr = 0;
      m_level = 0; m_comm = 0; m_latch = 0;
      e_push = 0; e_flush = 0; e_busy = 0; e_under = 0; e_din = '0;
      new_grant = -1;
   endtask

   // Advance the model by one clock using the inputs that were applied during that clock.
   task automatic model_step();
      int pop_acc, nlev, ncomm, eff, win_len;
      bit npush;
      pop_acc = (in_pop && m_level > 0 && m_mode != 2) ? 1 : 0;
      e_under = in_pop && m_level == 0 && m_mode != 2;
      nlev    = m_level + (e_push ? 1 : 0) - pop_acc;
      ncomm   = m_comm - pop_acc;
      npush   = 0;
      new_grant = -1;
      win_len = 0;
      case (m_mode)
         0: begin
            if (in_fl || m_latch) begin
               m_mode = 2; m_fl_left = FLUSH_CYC; m_latch = 0;
            end else begin
               for (int k = 0; k < NUM_REQ; k++) begin
                  int i;
                  i   = (m_rr + k) % NUM_REQ;
                  eff = (in_len[i] > MAX_BURST) ? MAX_BURST : in_len[i];
                  if (new_grant < 0 && in_req[i] && eff > 0 && eff <= DEPTH - m_comm) begin
                     new_grant = i;
                     win_len   = eff;
                  end
               end
               if (new_grant >= 0) begin
                  m_mode = 1; m_owner = new_grant; m_left = win_len;
                  ncomm  = ncomm + win_len;
                  m_rr   = (new_grant + 1) % NUM_REQ;
               end
            end
         end
         1: begin
            if (in_fl) m_latch = 1;
            if (in_valid[m_owner]) begin
               npush  = 1;
               e_din  = in_data[m_owner];
               m_left = m_left - 1;
               if (m_left == 0) m_mode = 0;
            end
         end
         default: begin
            m_fl_left = m_fl_left - 1;
            if (m_fl_left == 0) begin
               m_mode = 0; nlev = 0; ncomm = 0;
            end
         end
      endcase
      m_level = nlev;
      m_comm  = ncomm;
      e_push  = npush;
      e_flush = (m_mode == 2);
      e_busy  = (m_mode == 2) || m_latch;
      if (npush) m_pushes++;
   endtask

   task automatic compare_outputs();
      logic [NUM_REQ-1:0] e_grant;
      e_grant = '0;
      if (m_mode == 1) e_grant[m_owner] = 1'b1;
      check_val("grant", bus.Grant, e_grant);
      check_val("push", bus.Fifo_PUSH, e_push);
      if (e_push) check_val("din", bus.Fifo_DIN, e_din);
      check_val("level", bus.Level, m_level);
      check_val("underflow", bus.Underflow, e_under);
      check_val("push_flush", bus.Fifo_Push_Flush, e_flush);
      check_val("flush_busy", bus.Flush_Busy, e_busy);
      if (bus.Fifo_PUSH === 1'b1) d_pushes++;
   endtask

   task automatic gen_inputs(input int pop_pct, input int fl_per);
      if (new_grant >= 0 && $urandom_range(0, 1) == 0) in_req[new_grant] = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!in_req[i]) begin
            if ($urandom_range(0, 99) < 30) begin
               int r;
               r = $urandom_range(0, 99);
               in_req[i] = 1'b1;
               if (r < 5)       in_len[i] = 0;
               else if (r < 15) in_len[i] = $urandom_range(33, 63);
               else             in_len[i] = $urandom_range(1, 32);
            end
         end else if (in_len[i] == 0 && $urandom_range(0, 3) == 0) begin
            in_req[i] = 1'b0;
         end
         in_valid[i] = ($urandom_range(0, 3) != 0);
         in_data[i]  = $urandom;
      end
      in_pop = ($urandom_range(0, 99) < pop_pct);
      in_fl  = ($urandom_range(0, fl_per - 1) == 0);
      drive_inputs();
   endtask

   task automatic run_cycle(input int pop_pct, input int fl_per);
      @(negedge Clk);
      model_step();
      compare_outputs();
      gen_inputs(pop_pct, fl_per);
   endtask

   initial begin
      int w;
      n_cmp = 0; n_err = 0; m_pushes = 0; d_pushes = 0;
      Reset_N = 1'b0;
      clear_inputs();
      model_reset();
      repeat (3) @(negedge Clk);
      check_val("rst_grant", bus.Grant, '0);
      check_val("rst_level", bus.Level, '0);
      check_val("rst_push", bus.Fifo_PUSH, 1'b0);
      check_val("rst_busy", bus.Flush_Busy, 1'b0);
      Reset_N = 1'b1;

      // fill towards full, then drain past empty, then mixed traffic with frequent flushes
      for (int c = 0; c < 2000; c++) run_cycle(6, 1000);
      for (int c = 0; c < 2000; c++) run_cycle(75, 300);
      for (int c = 0; c < 2000; c++) run_cycle(50, 150);

      // asynchronous reset in the middle of a burst
      w = 0;
      while (m_mode != 1 && w < 2000) begin
         run_cycle(10, 100000);
         w++;
      end
      check_val("burst_wait_grant", |bus.Grant, 1'b1);
      #2;
      Reset_N = 1'b0;
      #1;
      check_val("arst_grant", bus.Grant, '0);
      check_val("arst_level", bus.Level, '0);
      check_val("arst_push", bus.Fifo_PUSH, 1'b0);
      check_val("arst_busy", bus.Flush_Busy, 1'b0);
      check_val("arst_flush", bus.Fifo_Push_Flush, 1'b0);
      check_val("arst_din", bus.Fifo_DIN, '0);
      clear_inputs();
      model_reset();
      @(negedge Clk);
      @(negedge Clk);
      Reset_N = 1'b1;
      for (int c = 0; c < 400; c++) run_cycle(30, 200);

      check_val("push_total", d_pushes, m_pushes);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
